sw_chain_counter: RTL and testbench
===================================

# sw_chain_counter

Parametrised cascaded stopwatch/timer counter: a chain of `STAGES` modulo counters (e.g. centiseconds, seconds, minutes), each with its own limit, advanced by a one-cycle tick strobe. It is the next generation of the per-digit stopwatch counters and replaces hand-chained instances in the display path. It adds up/down modes, preset load, lap capture and a run/stop/expired state machine with overflow and done strobes.

## Interface
- `STAGES`, 3: number of cascaded stages; stage 0 is least significant.
- `DW`, 7: bit width of each stage.
- `LIMITS`, {7'd60, 7'd60, 7'd100}: packed `STAGES*DW` vector. Slice k is the modulus of stage k. Each slice is ≥2 and ≤2^DW.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `i_tick`  in  1  one-cycle advance strobe (timebase)
- `i_start_stop`  in  1  one-cycle pulse; toggles IDLE/RUN
- `i_clear`  in  1  synchronous clear of counts and lap; forces IDLE
- `i_dir`  in  1  0 = count up, 1 = count down
- `i_load`  in  1  synchronous preset strobe
- `i_load_val`  in  STAGES*DW  preset value, same packing as `o_count`
- `i_lap`  in  1  capture current count into `o_lap`
- `o_count`  out  STAGES*DW  stage k occupies bits [k*DW +: DW]
- `o_lap`  out  STAGES*DW  last captured count
- `o_lap_valid`  out  1  one-cycle pulse after a capture
- `o_ovf`  out  1  one-cycle pulse on full-chain wrap (up mode)
- `o_done`  out  1  one-cycle pulse when the countdown reaches zero
- `o_running`  out  1  high in RUN

## Operation
- FSM states: IDLE, RUN, DONE. `o_running` = (state == RUN).
  - IDLE → RUN on `i_start_stop`.
  - RUN → IDLE on `i_start_stop`.
  - RUN → DONE on a countdown reaching zero.
  - DONE ignores `i_start_stop`. DONE → IDLE on `i_clear` or `i_load`.
- Per-cycle priority: `i_clear` > `i_load` > count advance.
  - Clear: zero all stages and `o_lap`, go to IDLE.
  - Load: write `i_load_val`, go to IDLE. Any slice ≥ its limit saturates to limit−1.
- Advance occurs only when state == RUN and `i_tick` = 1.
- Up mode (`i_dir`=0):
  - Stage 0 increments.
  - Stage k increments when every stage below it is at limit−1.
  - A stage at limit−1 that receives a carry wraps to 0.
  - When all stages are at limit−1, the whole chain wraps to 0, `o_ovf` pulses, and the FSM stays in RUN.
- Down mode (`i_dir`=1):
  - Stage 0 decrements.
  - Stage k decrements when every stage below it is 0.
  - A stage at 0 that receives a borrow becomes limit−1.
  - If the advance yields all-zero: `o_done` pulses and the FSM goes to DONE.
  - If the count is already all-zero in RUN with `i_dir`=1 (e.g. started at 0): the tick holds the count at zero, pulses `o_done` and goes to DONE. There is no wrap.
- `i_dir` is sampled on each advancing tick. Changing it mid-run takes effect on the next tick.
- Lap: `i_lap` copies the pre-update `o_count` into `o_lap` in any state. If `i_lap` and an advancing tick coincide, the lap holds the old value. `i_clear` in the same cycle wins: `o_lap` = 0 and `o_lap_valid` stays low.
- `i_start_stop` coincident with an advancing tick in RUN: the tick is applied, then the FSM goes to IDLE.
- Arithmetic is per-stage at `DW` bits. No stage ever holds a value ≥ its limit.

## Timing
- All outputs are registered. Reset values: `o_count`=0, `o_lap`=0, `o_lap_valid`=0, `o_ovf`=0, `o_done`=0, `o_running`=0, state IDLE.
- Count latency: 1 cycle from the `i_tick` edge to updated `o_count`.
- `o_ovf` and `o_done` assert in the same cycle as the wrapped or zero count, for exactly one cycle.
- `o_lap` and `o_lap_valid` update 1 cycle after `i_lap`.
- `o_running` rises/falls 1 cycle after `i_start_stop`.
- Asserting `rst` low mid-count clears everything immediately. Counting resumes only after a new `i_start_stop`.
- `i_tick` held high counts once per cycle; this is legal.

## Test plan
- Up wrap: load 59:59:98, start, 2 ticks → count 59:59:99, then 00:00:00 with `o_ovf`=1 for one cycle; `o_running` stays 1.
- Carry chain: load 00:59:99, start, 1 tick → 01:00:00; no `o_ovf`.
- Countdown: `i_dir`=1, load 00:01:01, start, 101 ticks → 00:00:00 with `o_done` pulse, `o_running`=0. A further start/stop and tick leave the count at 0; `i_load` returns to IDLE.
- Lap + tick collision: running at 00:00:41, `i_lap` and `i_tick` in the same cycle → `o_lap`=00:00:41, `o_count`=00:00:42, `o_lap_valid` pulse.
- Priority and saturation:
  - `i_clear`+`i_load`+`i_tick` together → all zero, IDLE.
  - Load 75:80:120 → 59:59:99.
- Reset mid-run: drop `rst` while counting at 12:34:56 → all outputs 0 asynchronously; ticks after release do not count until `i_start_stop`.

Source files
------------

// File: rtl/sw_chain_counter_if.sv
// sw_chain_counter_if: control strobes and count/lap/status outputs of the chained stopwatch counter.
interface sw_chain_counter_if #(
  parameter int STAGES = 3,
  parameter int DW     = 7
);
  logic                   tick, start_stop, clear, dir, load, lap;
  logic [STAGES*DW-1:0]   load_val, count, lap_count;
  logic                   lap_valid, ovf, done, running;
  modport master (
    output tick, start_stop, clear, dir, load, lap, load_val,
    input  count, lap_count, lap_valid, ovf, done, running
  );
  modport slave (
    input  tick, start_stop, clear, dir, load, lap, load_val,
    output count, lap_count, lap_valid, ovf, done, running
  );
endinterface

// File: rtl/sw_chain_counter.sv
// sw_chain_counter: cascaded modulo stopwatch/timer with up/down, preset, lap capture and run/stop/done FSM.
module sw_chain_counter #(
  parameter int                   STAGES = 3,
  parameter int                   DW     = 7,
  parameter logic [STAGES*DW-1:0] LIMITS = {7'd60, 7'd60, 7'd100}
) (
  input logic               clk,
  input logic               rst_n,
  sw_chain_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                     state, state_nx;
  logic [STAGES-1:0][DW-1:0]  lim_m1, cnt, cnt_nx, adv, ld;
  logic [STAGES*DW-1:0]       lap_q;
  logic [STAGES:0]            en;
  logic                       step, ovf_nx, done_nx, lap_v, ovf_q, done_q;
  // A limit of 2^DW is stored as 0 in its slice; subtracting 1 still yields the right max
  for (genvar k = 0; k < STAGES; k++) begin : g_lim
    assign lim_m1[k] = LIMITS[k*DW +: DW] - DW'(1);
  end
  always_comb begin
    en    = '0;
    en[0] = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      adv[k]  = !en[k] ? cnt[k] :
                bus.dir ? (cnt[k] == '0 ? lim_m1[k] : cnt[k] - DW'(1)) :
                (cnt[k] == lim_m1[k] ? '0 : cnt[k] + DW'(1));
      en[k+1] = en[k] && (bus.dir ? cnt[k] == '0 : cnt[k] == lim_m1[k]);
      ld[k]   = bus.load_val[k*DW +: DW] > lim_m1[k] ? lim_m1[k] : bus.load_val[k*DW +: DW];
    end
    step     = state == RUN && bus.tick && !bus.clear && !bus.load;
    // en[STAGES] means all-max when counting up and all-zero when counting down
    ovf_nx   = step && !bus.dir && en[STAGES];
    done_nx  = step && bus.dir && (en[STAGES] || adv == '0);
    cnt_nx   = bus.clear ? '0 : bus.load ? ld : (step && !(bus.dir && en[STAGES])) ? adv : cnt;
    state_nx = (bus.clear || bus.load) ? IDLE :
               done_nx ? DONE :
               (state == IDLE && bus.start_stop) ? RUN :
               (state == RUN && bus.start_stop) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      lap_q  <= '0;
      lap_v  <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      lap_q  <= bus.clear ? '0 : bus.lap ? cnt : lap_q;
      lap_v  <= bus.lap && !bus.clear;
      ovf_q  <= ovf_nx;
      done_q <= done_nx;
    end
  end
  assign bus.count     = cnt;
  assign bus.lap_count = lap_q;
  assign bus.lap_valid = lap_v;
  assign bus.ovf       = ovf_q;
  assign bus.done      = done_q;
  assign bus.running   = state == RUN;
endmodule

// File: tb/tb_sw_chain_counter.sv
// tb_sw_chain_counter: directed scenarios plus random stimulus against a mixed-radix total-count model.
module tb_sw_chain_counter;
  localparam int STAGES = 3;
  localparam int DW     = 7;
  localparam int W      = STAGES * DW;
  localparam int LIM [STAGES] = '{100, 60, 60};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sw_chain_counter_if #(.STAGES(STAGES), .DW(DW)) bus ();
  sw_chain_counter #(.STAGES(STAGES), .DW(DW), .LIMITS({7'd60, 7'd60, 7'd100})) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int     n_tests = 0, n_fail = 0;
  longint m_total, m_lap;
  int     m_state;
  bit     m_lap_valid, m_ovf, m_done;
  logic [2*W+3:0] dut_vec;
  assign dut_vec = {bus.count, bus.lap_count, bus.lap_valid, bus.ovf, bus.done, bus.running};

  function automatic longint span();
    longint s = 1;
    for (int k = 0; k < STAGES; k++) s *= LIM[k];
    return s;
  endfunction
  function automatic logic [W-1:0] pack(longint t);
    logic [W-1:0] p;
    for (int k = 0; k < STAGES; k++) begin
      p[k*DW +: DW] = DW'(t % LIM[k]);
      t /= LIM[k];
    end
    return p;
  endfunction
  function automatic longint unpack_sat(logic [W-1:0] v);
    longint tot = 0, mul = 1, d;
    for (int k = 0; k < STAGES; k++) begin
      d = longint'(v[k*DW +: DW]);
      if (d >= LIM[k]) d = LIM[k] - 1;
      tot += d * mul;
      mul *= LIM[k];
    end
    return tot;
  endfunction
  function automatic longint hmc(int h, int m, int c);
    return (longint'(h) * 60 + m) * 100 + c;
  endfunction
  function automatic logic [2*W+3:0] exp_vec();
    return {pack(m_total), pack(m_lap), m_lap_valid, m_ovf, m_done, m_state == 1};
  endfunction
  function automatic void model_reset();
    m_total = 0; m_lap = 0; m_state = 0; m_lap_valid = 0; m_ovf = 0; m_done = 0;
  endfunction

  // Model works on the whole count as one integer in mixed radix
  task automatic model_step();
    bit adv = (m_state == 1) && bus.tick;
    m_ovf = 0; m_done = 0;
    if (bus.clear) begin
      m_total = 0; m_lap = 0; m_lap_valid = 0; m_state = 0;
    end else begin
      m_lap_valid = bus.lap;
      if (bus.lap) m_lap = m_total;
      if (bus.load) begin
        m_total = unpack_sat(bus.load_val); m_state = 0;
      end else begin
        if (adv && !bus.dir) begin
          if (m_total == span() - 1) begin m_total = 0; m_ovf = 1; end
          else m_total++;
        end else if (adv) begin
          if (m_total != 0) m_total--;
          m_done = (m_total == 0);
        end
        if (m_done) m_state = 2;
        else if (m_state == 0 && bus.start_stop) m_state = 1;
        else if (m_state == 1 && bus.start_stop) m_state = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    bus.tick = 0; bus.start_stop = 0; bus.clear = 0; bus.load = 0; bus.lap = 0;
  endtask

  task automatic do_load(longint t);
    bus.load = 1; bus.load_val = pack(t); cycle();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL reset: got %h want 0", dut_vec); end
    rst_n = 1;
    cycle();
    n_tests++;
    if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_up_wrap();
    bus.dir = 0;
    do_load(hmc(59, 59, 98));
    bus.start_stop = 1; cycle();
    bus.tick = 1; cycle();
    n_tests++;
    if (bus.count !== pack(hmc(59, 59, 99)) || bus.ovf !== 1'b0) begin
      n_fail++; $display("FAIL up_pre_wrap: got %h ovf %b want %h ovf 0", bus.count, bus.ovf, pack(hmc(59, 59, 99)));
    end
    bus.tick = 1; cycle();
    n_tests++;
    if (bus.count !== '0 || bus.ovf !== 1'b1 || bus.running !== 1'b1) begin
      n_fail++; $display("FAIL up_wrap: got %h ovf %b run %b want 0 ovf 1 run 1", bus.count, bus.ovf, bus.running);
    end
    cycle();
    n_tests++;
    if (bus.ovf !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL up_ovf_pulse: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_carry();
    do_load(hmc(0, 59, 99));
    bus.start_stop = 1; cycle();
    bus.tick = 1; cycle();
    n_tests++;
    if (bus.count !== pack(hmc(1, 0, 0)) || bus.ovf !== 1'b0) begin
      n_fail++; $display("FAIL carry: got %h ovf %b want %h ovf 0", bus.count, bus.ovf, pack(hmc(1, 0, 0)));
    end
  endtask

  task automatic test_countdown();
    bus.dir = 1;
    do_load(hmc(0, 1, 1));
    bus.start_stop = 1; cycle();
    for (int i = 0; i < 100; i++) begin bus.tick = 1; cycle(); end
    n_tests++;
    if (bus.count !== pack(1) || bus.done !== 1'b0 || bus.running !== 1'b1) begin
      n_fail++; $display("FAIL down_pre_zero: got %h done %b run %b want %h 0 1", bus.count, bus.done, bus.running, pack(1));
    end
    bus.tick = 1; cycle();
    n_tests++;
    if (bus.count !== '0 || bus.done !== 1'b1 || bus.running !== 1'b0) begin
      n_fail++; $display("FAIL down_zero: got %h done %b run %b want 0 1 0", bus.count, bus.done, bus.running);
    end
    bus.start_stop = 1; cycle();
    bus.tick = 1; cycle();
    n_tests++;
    if (bus.count !== '0 || bus.running !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL done_hold: got %h run %b done %b want 0 0 0", bus.count, bus.running, bus.done);
    end
    do_load(0);
    bus.start_stop = 1; cycle();
    n_tests++;
    if (bus.running !== 1'b1) begin n_fail++; $display("FAIL load_from_done: run %b want 1", bus.running); end
    bus.tick = 1; cycle();
    n_tests++;
    if (bus.count !== '0 || bus.done !== 1'b1 || bus.running !== 1'b0) begin
      n_fail++; $display("FAIL down_from_zero: got %h done %b run %b want 0 1 0", bus.count, bus.done, bus.running);
    end
  endtask

  task automatic test_lap_collision();
    bus.dir = 0;
    do_load(41);
    bus.start_stop = 1; cycle();
    bus.lap = 1; bus.tick = 1; cycle();
    n_tests++;
    if (bus.lap_count !== pack(41) || bus.count !== pack(42) || bus.lap_valid !== 1'b1) begin
      n_fail++; $display("FAIL lap_collision: lap %h cnt %h v %b want %h %h 1", bus.lap_count, bus.count, bus.lap_valid, pack(41), pack(42));
    end
    cycle();
    n_tests++;
    if (bus.lap_valid !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL lap_pulse: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_priority();
    bus.clear = 1; bus.load = 1; bus.load_val = pack(hmc(5, 5, 5)); bus.tick = 1; bus.lap = 1; cycle();
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL clear_priority: got %h want 0", dut_vec); end
    bus.load = 1; bus.load_val = {7'd75, 7'd80, 7'd120}; cycle();
    n_tests++;
    if (bus.count !== pack(hmc(59, 59, 99)) || bus.running !== 1'b0) begin
      n_fail++; $display("FAIL saturate: got %h run %b want %h 0", bus.count, bus.running, pack(hmc(59, 59, 99)));
    end
  endtask

  task automatic test_reset_mid();
    do_load(hmc(12, 34, 55));
    bus.start_stop = 1; cycle();
    bus.tick = 1; bus.lap = 1; cycle();
    #3 rst_n = 0;
    #1;
    model_reset();
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL async_reset: got %h want 0", dut_vec); end
    @(posedge clk);
    #1 rst_n = 1;
    repeat (3) begin bus.tick = 1; cycle(); end
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL post_reset_idle: got %h want 0", dut_vec); end
    bus.start_stop = 1; cycle();
    bus.tick = 1; cycle();
    n_tests++;
    if (bus.count !== pack(1) || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL post_reset_run: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.tick       = $urandom_range(0, 1) == 1;
      bus.start_stop = $urandom_range(0, 15) == 0;
      bus.clear      = $urandom_range(0, 99) == 0;
      bus.load       = $urandom_range(0, 39) == 0;
      bus.lap        = $urandom_range(0, 7) == 0;
      bus.load_val   = $urandom_range(0, 2) == 0 ? W'($urandom_range(0, 300)) : W'($urandom);
      if ($urandom_range(0, 31) == 0) bus.dir = ~bus.dir;
      cycle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    bus.tick = 0; bus.start_stop = 0; bus.clear = 0; bus.dir = 0;
    bus.load = 0; bus.lap = 0; bus.load_val = '0;
    test_reset();
    test_up_wrap();
    test_carry();
    test_countdown();
    test_lap_collision();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
